// File: rtl/brick_map_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : brick_map_writer_pkg
// Purpose  : grid geometry, cell codes and FSM encoding shared by the brick
//            map writer and the pixel address generator
// Revision : 1.0
// ============================================================================
package brick_map_writer_pkg;

   localparam int GRID_COLS    = 20;
   localparam int GRID_ROWS    = 24;
   localparam int GRID_CODE_W  = 3;
   localparam int GRID_BRICK_W = 32;
   localparam int GRID_BRICK_H = 20;
   localparam int GRID_CELLS   = GRID_COLS * GRID_ROWS;

   localparam logic [2:0] CODE_EMPTY  = 3'd0;
   localparam logic [2:0] CODE_NORMAL = 3'd1;
   localparam logic [2:0] CODE_WALL   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIT  = 2'd1,
      ST_LOAD = 2'd2
   } state_t;

   function automatic logic is_breakable(input logic [2:0] code);
      return (code != CODE_EMPTY) && (code != CODE_WALL);
   endfunction

   // Empty and wall cells are left as they are; everything else steps down.
   function automatic logic [2:0] hit_result(input logic [2:0] code);
      if (!is_breakable(code)) begin
         return code;
      end
      return code - 3'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/brick_stage_rom.sv
`default_nettype none
// ============================================================================
// Module   : brick_stage_rom
// Purpose  : combinational stage pattern table, (stage, row, col) -> code
// Revision : 1.0
// ============================================================================
module brick_stage_rom
   import brick_map_writer_pkg::*;
#(
   parameter int COLS   = GRID_COLS,
   parameter int ROW_W  = 5,
   parameter int COL_W  = 5,
   parameter int CODE_W = GRID_CODE_W
)(
   input  logic [1:0]        stage,
   input  logic [ROW_W-1:0]  row,
   input  logic [COL_W-1:0]  col,
   output logic [CODE_W-1:0] code
);

   always_comb begin
      code = CODE_EMPTY;
      case (stage)
         2'd0: begin
            if (row >= ROW_W'(2) && row <= ROW_W'(7)) begin
               code = CODE_NORMAL;
            end
         end
         2'd1: begin
            if (row == ROW_W'(2)) begin
               code = 3'd3;
            end else if (row >= ROW_W'(3) && row <= ROW_W'(6)) begin
               code = CODE_NORMAL;
            end else if (row == ROW_W'(8) &&
                         (col == COL_W'(0) || col == COL_W'(COLS - 1))) begin
               code = CODE_WALL;
            end
         end
         2'd2: begin
            // Checkerboard: NORMAL where row+col is even.
            if (row >= ROW_W'(2) && row <= ROW_W'(9) && (row[0] == col[0])) begin
               code = CODE_NORMAL;
            end
         end
         default: code = CODE_EMPTY;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/brick_map_writer.sv
`default_nettype none
// ============================================================================
// Module   : brick_map_writer
// Purpose  : owns the brick grid; stage loads, hit processing, breakable count
// Revision : 1.0
// ============================================================================
module brick_map_writer
   import brick_map_writer_pkg::*;
#(
   parameter int COLS    = GRID_COLS,
   parameter int ROWS    = GRID_ROWS,
   parameter int CODE_W  = GRID_CODE_W,
   parameter int BRICK_W = GRID_BRICK_W,
   parameter int BRICK_H = GRID_BRICK_H
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load,
   input  logic [1:0]                    stage_sel,
   input  logic                          hit_valid,
   output logic                          hit_ready,
   input  logic [9:0]                    hit_x,
   input  logic [9:0]                    hit_y,
   output logic                          hit_done,
   output logic                          hit_brick,
   output logic [CODE_W-1:0]             hit_code,
   output logic [COLS*ROWS*CODE_W-1:0]   bricks,
   output logic [8:0]                    remain_cnt,
   output logic                          cleared,
   output logic                          busy
);

   localparam int C_CELLS   = COLS * ROWS;
   localparam int C_GRID_W  = C_CELLS * CODE_W;
   localparam int C_COL_W   = $clog2(COLS);
   localparam int C_ROW_W   = $clog2(ROWS);
   localparam int C_IDX_W   = $clog2(C_CELLS);
   localparam int C_X_SHIFT = $clog2(BRICK_W);
   localparam logic [9:0]         C_X_LIMIT  = 10'(COLS * BRICK_W);
   localparam logic [9:0]         C_Y_LIMIT  = 10'(ROWS * BRICK_H);
   localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_CELLS - 1);

   state_t                r_state;
   state_t                w_next_state;

   logic [C_GRID_W-1:0]   r_bricks;
   logic [8:0]            r_remain;
   logic                  r_loaded;
   logic                  r_cleared;
   logic                  r_busy;
   logic                  r_hit_done;
   logic                  r_hit_brick;
   logic [CODE_W-1:0]     r_hit_code;

   logic [C_COL_W-1:0]    r_hit_col;
   logic [C_ROW_W-1:0]    r_hit_row;
   logic                  r_hit_in_range;

   logic [1:0]            r_stage;
   logic [C_IDX_W-1:0]    r_ld_idx;
   logic [C_ROW_W-1:0]    r_ld_row;
   logic [C_COL_W-1:0]    r_ld_col;

   logic                  w_hit_accept;
   logic [C_COL_W-1:0]    w_col_calc;
   logic [C_ROW_W-1:0]    w_row_calc;
   logic                  w_in_range;
   logic [C_IDX_W-1:0]    w_hit_idx;
   logic [CODE_W-1:0]     w_old_code;
   logic [CODE_W-1:0]     w_rom_code;

   assign hit_ready    = (r_state == ST_IDLE) && !load;
   assign w_hit_accept = hit_valid && hit_ready;

   // Column is a shift because BRICK_W is a power of two; row needs a divide.
   assign w_col_calc = C_COL_W'(hit_x >> C_X_SHIFT);
   assign w_row_calc = C_ROW_W'(hit_y / 10'(BRICK_H));
   assign w_in_range = (hit_x < C_X_LIMIT) && (hit_y < C_Y_LIMIT);

   assign w_hit_idx  = C_IDX_W'(r_hit_row) * C_IDX_W'(COLS) + C_IDX_W'(r_hit_col);
   assign w_old_code = r_bricks[w_hit_idx * CODE_W +: CODE_W];

   brick_stage_rom #(
      .COLS   (COLS),
      .ROW_W  (C_ROW_W),
      .COL_W  (C_COL_W),
      .CODE_W (CODE_W)
   ) u_stage_rom (
      .stage (r_stage),
      .row   (r_ld_row),
      .col   (r_ld_col),
      .code  (w_rom_code)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (load) begin
               w_next_state = ST_LOAD;
            end else if (w_hit_accept) begin
               w_next_state = ST_HIT;
            end
         end
         ST_HIT:  w_next_state = load ? ST_LOAD : ST_IDLE;
         ST_LOAD: begin
            if (!load && r_ld_idx == C_LAST_IDX) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bricks       <= '0;
         r_remain       <= '0;
         r_loaded       <= 1'b0;
         r_cleared      <= 1'b0;
         r_busy         <= 1'b0;
         r_hit_done     <= 1'b0;
         r_hit_brick    <= 1'b0;
         r_hit_code     <= '0;
         r_hit_col      <= '0;
         r_hit_row      <= '0;
         r_hit_in_range <= 1'b0;
         r_stage        <= '0;
         r_ld_idx       <= '0;
         r_ld_row       <= '0;
         r_ld_col       <= '0;
      end else begin
         r_hit_done <= 1'b0;
         r_busy     <= (w_next_state != ST_IDLE);
         r_cleared  <= r_loaded && (r_remain == 9'd0) && (r_state == ST_IDLE) && !load;

         if (w_hit_accept) begin
            r_hit_col      <= w_col_calc;
            r_hit_row      <= w_row_calc;
            r_hit_in_range <= w_in_range;
         end

         if (r_state == ST_HIT) begin
            r_hit_done <= 1'b1;
            if (r_hit_in_range) begin
               r_hit_code  <= w_old_code;
               r_hit_brick <= (w_old_code != CODE_EMPTY);
               r_bricks[w_hit_idx * CODE_W +: CODE_W] <= hit_result(w_old_code);
               if (w_old_code == CODE_NORMAL) begin
                  r_remain <= r_remain - 9'd1;
               end
            end else begin
               r_hit_code  <= '0;
               r_hit_brick <= 1'b0;
            end
         end

         if (r_state == ST_LOAD && !load) begin
            r_bricks[r_ld_idx * CODE_W +: CODE_W] <= w_rom_code;
            if (is_breakable(w_rom_code)) begin
               r_remain <= r_remain + 9'd1;
            end
            r_ld_idx <= r_ld_idx + C_IDX_W'(1);
            if (r_ld_col == C_COL_W'(COLS - 1)) begin
               r_ld_col <= '0;
               r_ld_row <= r_ld_row + C_ROW_W'(1);
            end else begin
               r_ld_col <= r_ld_col + C_COL_W'(1);
            end
            if (r_ld_idx == C_LAST_IDX) begin
               r_loaded <= 1'b1;
            end
         end

         // A new load pulse wins over everything above, including a hit's count update.
         if (load) begin
            r_stage  <= stage_sel;
            r_ld_idx <= '0;
            r_ld_row <= '0;
            r_ld_col <= '0;
            r_remain <= '0;
            r_loaded <= 1'b0;
         end
      end
   end

   assign bricks     = r_bricks;
   assign remain_cnt = r_remain;
   assign cleared    = r_cleared;
   assign busy       = r_busy;
   assign hit_done   = r_hit_done;
   assign hit_brick  = r_hit_brick;
   assign hit_code   = r_hit_code;

endmodule
`default_nettype wire

// File: tb/tb_brick_map_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_brick_map_writer
// Purpose  : self-checking bench for brick_map_writer against a grid model
// Revision : 1.0
// ============================================================================
module tb_brick_map_writer;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load;
   logic [1:0]    stage_sel;
   logic          hit_valid;
   logic          hit_ready;
   logic [9:0]    hit_x;
   logic [9:0]    hit_y;
   logic          hit_done;
   logic          hit_brick;
   logic [2:0]    hit_code;
   logic [1439:0] bricks;
   logic [8:0]    remain_cnt;
   logic          cleared;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;

   int m_grid[480];
   bit m_loaded = 1'b0;

   typedef struct {
      int x;
      int y;
      int brick;
      int code;
      int remain;
   } hit_vec_t;

   hit_vec_t tbl[12];

   brick_map_writer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .stage_sel  (stage_sel),
      .hit_valid  (hit_valid),
      .hit_ready  (hit_ready),
      .hit_x      (hit_x),
      .hit_y      (hit_y),
      .hit_done   (hit_done),
      .hit_brick  (hit_brick),
      .hit_code   (hit_code),
      .bricks     (bricks),
      .remain_cnt (remain_cnt),
      .cleared    (cleared),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no summary expected summary");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int pattern(input int st, input int r, input int c);
      case (st)
         0: return (r >= 2 && r <= 7) ? 1 : 0;
         1: begin
            if (r == 2) return 3;
            if (r >= 3 && r <= 6) return 1;
            if (r == 8 && (c == 0 || c == 19)) return 7;
            return 0;
         end
         2: return (r >= 2 && r <= 9 && ((r + c) % 2 == 0)) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic int model_remain();
      int n = 0;
      for (int i = 0; i < 480; i++) begin
         if (m_grid[i] >= 1 && m_grid[i] <= 6) n++;
      end
      return n;
   endfunction

   task automatic model_hit(input int x, input int y, output int eb, output int ec);
      int idx;
      int old;
      if (x < 640 && y < 480) begin
         idx = (y / 20) * 20 + (x / 32);
         old = m_grid[idx];
         ec  = old;
         eb  = (old != 0) ? 1 : 0;
         if (old >= 1 && old <= 6) m_grid[idx] = old - 1;
      end else begin
         eb = 0;
         ec = 0;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 480; i++) m_grid[i] = 0;
      m_loaded = 1'b0;
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_grid(input string name);
      int bad   = 0;
      int first = -1;
      int got_f = 0;
      for (int i = 0; i < 480; i++) begin
         if (bricks[3*i +: 3] !== 3'(m_grid[i])) begin
            if (first < 0) begin
               first = i;
               got_f = int'(bricks[3*i +: 3]);
            end
            bad++;
         end
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL %s: %0d cells differ, cell %0d got %0d expected %0d",
                  name, bad, first, got_f, m_grid[first]);
      end
   endtask

   function automatic int get_cell(input int r, input int c);
      return int'(bricks[3*(c + 20*r) +: 3]);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus tasks ----------------
   task automatic start_load(input int st, input bit hv);
      load      = 1'b1;
      stage_sel = 2'(st);
      hit_valid = hv;
      hit_x     = 10'd40;
      hit_y     = 10'd45;
      #1;
      check("hit_ready_during_load", hit_ready, 0);
      @(posedge clk);
      #1;
      load      = 1'b0;
      hit_valid = 1'b0;
      m_loaded  = 1'b0;
   endtask

   task automatic finish_load(input int st);
      bit seen = 1'b0;
      step();
      check("busy_load_start", busy, 1);
      check("cleared_load_start", cleared, 0);
      repeat (478) begin
         step();
         seen = seen | hit_done;
      end
      check("busy_load_end", busy, 1);
      step();
      step();
      for (int r = 0; r < 24; r++)
         for (int c = 0; c < 20; c++)
            m_grid[r*20 + c] = pattern(st, r, c);
      m_loaded = 1'b1;
      check("busy_after_load", busy, 0);
      check("remain_after_load", remain_cnt, model_remain());
      check("cleared_after_load", cleared, (model_remain() == 0) ? 1 : 0);
      check("no_hit_done_in_load", seen, 0);
      check_grid("grid_after_load");
   endtask

   task automatic do_hit(input int x, input int y, output int g_brick, output int g_code, output int g_remain);
      int eb;
      int ec;
      hit_valid = 1'b1;
      hit_x     = 10'(x);
      hit_y     = 10'(y);
      #1;
      check("hit_ready_idle", hit_ready, 1);
      @(posedge clk);
      #1;
      hit_valid = 1'b0;
      check("hit_done_early", hit_done, 0);
      step();
      model_hit(x, y, eb, ec);
      g_brick  = int'(hit_brick);
      g_code   = int'(hit_code);
      g_remain = int'(remain_cnt);
      check("hit_done", hit_done, 1);
      check("hit_brick", hit_brick, eb);
      check("hit_code", hit_code, ec);
      check("hit_remain", remain_cnt, model_remain());
      step();
      check("hit_done_pulse", hit_done, 0);
      check("hit_cleared", cleared, (m_loaded && model_remain() == 0) ? 1 : 0);
   endtask

   task automatic reset_now(input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      check({tag, "_busy"}, busy, 0);
      check({tag, "_hit_ready"}, hit_ready, 1);
      check({tag, "_remain"}, remain_cnt, 0);
      check({tag, "_cleared"}, cleared, 0);
      check({tag, "_hit_done"}, hit_done, 0);
      check({tag, "_hit_brick"}, hit_brick, 0);
      check({tag, "_hit_code"}, hit_code, 0);
      check_grid({tag, "_grid"});
      rst_n = 1'b1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int gb;
      int gc;
      int gr;
      int eb;
      int ec;
      int x;
      int y;

      tbl[0]  = '{163,  45, 1, 3, 100};
      tbl[1]  = '{163,  45, 1, 2, 100};
      tbl[2]  = '{163,  45, 1, 1,  99};
      tbl[3]  = '{163,  45, 0, 0,  99};
      tbl[4]  = '{ 10, 161, 1, 7,  99};
      tbl[5]  = '{ 10, 161, 1, 7,  99};
      tbl[6]  = '{700,  10, 0, 0,  99};
      tbl[7]  = '{639, 479, 0, 0,  99};
      tbl[8]  = '{640, 100, 0, 0,  99};
      tbl[9]  = '{100, 480, 0, 0,  99};
      tbl[10] = '{639, 179, 1, 7,  99};
      tbl[11] = '{  0,  60, 1, 1,  98};

      rst_n     = 1'b0;
      load      = 1'b0;
      stage_sel = 2'd0;
      hit_valid = 1'b0;
      hit_x     = '0;
      hit_y     = '0;
      model_reset();
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_hit_ready", hit_ready, 1);
      check("rst_remain", remain_cnt, 0);
      check("rst_cleared", cleared, 0);
      check("rst_hit_done", hit_done, 0);
      check("rst_hit_brick", hit_brick, 0);
      check("rst_hit_code", hit_code, 0);
      check_grid("rst_grid");
      rst_n = 1'b1;
      step();

      // Stage 0 with a simultaneous hit request that must be ignored.
      start_load(0, 1'b1);
      finish_load(0);
      check("s0_remain", remain_cnt, 120);
      check("s0_cell_2_0", get_cell(2, 0), 1);
      check("s0_cell_7_19", get_cell(7, 19), 1);
      check("s0_cell_1_19", get_cell(1, 19), 0);
      check("s0_cell_8_0", get_cell(8, 0), 0);

      do_hit(40, 45, gb, gc, gr);
      check("s0_hit_code", gc, 1);
      check("s0_hit_remain", gr, 119);
      check("s0_cell_2_1", get_cell(2, 1), 0);

      // Stage 1 table of hits.
      start_load(1, 1'b0);
      finish_load(1);
      check("s1_remain", remain_cnt, 100);
      for (int i = 0; i < 12; i++) begin
         do_hit(tbl[i].x, tbl[i].y, gb, gc, gr);
         check($sformatf("tbl%0d_brick", i), gb, tbl[i].brick);
         check($sformatf("tbl%0d_code", i), gc, tbl[i].code);
         check($sformatf("tbl%0d_remain", i), gr, tbl[i].remain);
         check_grid($sformatf("tbl%0d_grid", i));
      end

      // Back-to-back hits: the second is accepted two cycles after the first.
      hit_valid = 1'b1;
      hit_x     = 10'd32;
      hit_y     = 10'd61;
      step();
      check("b2b_ready_in_hit", hit_ready, 0);
      hit_x = 10'd64;
      step();
      model_hit(32, 61, eb, ec);
      check("b2b_a_done", hit_done, 1);
      check("b2b_a_code", hit_code, ec);
      check("b2b_ready_again", hit_ready, 1);
      step();
      hit_valid = 1'b0;
      check("b2b_b_not_done_yet", hit_done, 0);
      step();
      model_hit(64, 61, eb, ec);
      check("b2b_b_done", hit_done, 1);
      check("b2b_b_code", hit_code, ec);
      check("b2b_remain", remain_cnt, 96);
      check_grid("b2b_grid");
      step();

      // Empty stage clears.
      start_load(3, 1'b0);
      finish_load(3);
      check("s3_cleared", cleared, 1);

      // Restart mid-load with a new stage.
      start_load(3, 1'b0);
      repeat (199) step();
      start_load(0, 1'b0);
      finish_load(0);
      check("restart_remain", remain_cnt, 120);

      // Load arriving during HIT: hit completes, then the load runs.
      hit_valid = 1'b1;
      hit_x     = 10'd40;
      hit_y     = 10'd45;
      step();
      hit_valid = 1'b0;
      load      = 1'b1;
      stage_sel = 2'd3;
      step();
      model_hit(40, 45, eb, ec);
      check("ld_in_hit_done", hit_done, 1);
      check("ld_in_hit_code", hit_code, ec);
      load     = 1'b0;
      m_loaded = 1'b0;
      finish_load(3);

      // Randomised hits and loads against the model.
      start_load(2, 1'b0);
      finish_load(2);
      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 24) == 0) begin
            start_load(int'($urandom_range(0, 3)), 1'b0);
            finish_load(m_grid_stage_dummy(stage_sel));
         end else begin
            x = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 639)) : int'($urandom_range(0, 1023));
            y = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 479)) : int'($urandom_range(0, 1023));
            do_hit(x, y, gb, gc, gr);
            if (k % 10 == 0) check_grid("rand_grid");
         end
      end
      check_grid("rand_grid_final");

      // Reset in the middle of a load.
      start_load(0, 1'b0);
      repeat (99) step();
      reset_now("rst_in_load");
      step();
      check("rst_in_load_idle", busy, 0);

      // Reset in the middle of a hit.
      start_load(0, 1'b0);
      finish_load(0);
      hit_valid = 1'b1;
      hit_x     = 10'd40;
      hit_y     = 10'd45;
      step();
      hit_valid = 1'b0;
      reset_now("rst_in_hit");
      step();
      check("rst_in_hit_no_done", hit_done, 0);
      step();
      check("rst_in_hit_no_done2", hit_done, 0);
      check_grid("rst_in_hit_grid");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // The stage for a random load is whatever was driven on stage_sel at the pulse.
   function automatic int m_grid_stage_dummy(input logic [1:0] s);
      return int'(s);
   endfunction

endmodule
`default_nettype wire
